// File: rtl/ad7760_bus_sched_if.sv
// Signal bundle between the AD7760 bus scheduler and its neighbours:
// pad-side bus, configuration requester and sample FIFO write port.
interface ad7760_bus_sched_if;
  logic        drdy_n;
  logic        rd_en;
  logic        cfg_req;
  logic [15:0] cfg_addr;
  logic [15:0] cfg_data;
  logic        cfg_busy;
  logic        cfg_ack;
  logic        fifo_full;
  logic [15:0] bus_in;
  logic [15:0] bus_out;
  logic        bus_oe;
  logic        cs_n;
  logic        r_n_w;
  logic [31:0] smp_data;
  logic        smp_valid;
  logic [7:0]  ovr_cnt;

  modport master (
    input  drdy_n, rd_en, cfg_req, cfg_addr, cfg_data, fifo_full, bus_in,
    output cfg_busy, cfg_ack, bus_out, bus_oe, cs_n, r_n_w, smp_data, smp_valid, ovr_cnt
  );

  modport slave (
    output drdy_n, rd_en, cfg_req, cfg_addr, cfg_data, fifo_full, bus_in,
    input  cfg_busy, cfg_ack, bus_out, bus_oe, cs_n, r_n_w, smp_data, smp_valid, ovr_cnt
  );
endinterface

// File: rtl/ad7760_bus_sched.sv
// Time-shares the AD7760 parallel bus between two-word register writes and
// DRDY-triggered two-word sample reads; counts samples that could not be delivered.
module ad7760_bus_sched #(
  parameter int WR_CS_CYCLES  = 8,
  parameter int WR_GAP_CYCLES = 8,
  parameter int RD_CS_CYCLES  = 2
) (
  input  logic               mclk,
  input  logic               i_rest,
  ad7760_bus_sched_if.master bus
);

  localparam int WR_MAX  = (WR_CS_CYCLES > WR_GAP_CYCLES) ? WR_CS_CYCLES : WR_GAP_CYCLES;
  localparam int CNT_MAX = (WR_MAX > RD_CS_CYCLES) ? WR_MAX : RD_CS_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] WR_CS_LAST  = CNT_W'(WR_CS_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_GAP_LAST = CNT_W'(WR_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_CS_LAST  = CNT_W'(RD_CS_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, WR_ADR, WR_ADR_GAP, WR_VAL, WR_VAL_GAP, WR_DONE,
    RD_MSW, RD_GAP, RD_LSW, RD_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;
  logic             drdy_p0, drdy_p1, drdy_p2;
  logic             drdy_fall, drdy_pend;
  logic             start_rd, cfg_take, ovr_drdy, ovr_fifo;
  logic             cfg_busy;
  logic [7:0]       ovr_cnt;
  logic [31:0]      smp_data;
  logic [15:0]      addr_q, data_q, msw_q;
  logic             cs_n, r_n_w, bus_oe, cfg_ack, smp_valid;
  logic [15:0]      bus_out;

  function automatic logic [7:0] sat_add8(input logic [7:0] acc, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, acc} + {7'd0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // p0/p1 resynchronise DRDY, p2 holds the previous synchronised level for edge detect
  assign drdy_fall = drdy_p2 & ~drdy_p1;
  assign cfg_take  = bus.cfg_req & ~cfg_busy;
  assign ovr_drdy  = drdy_fall & bus.rd_en & drdy_pend & ~start_rd;
  assign ovr_fifo  = (state == RD_DONE) & bus.fifo_full;

  always_comb begin
    state_nxt = state;
    cnt_last  = 1'b0;
    start_rd  = 1'b0;
    cs_n      = 1'b1;
    r_n_w     = 1'b1;
    bus_oe    = 1'b0;
    bus_out   = 16'h0000;
    cfg_ack   = 1'b0;
    smp_valid = 1'b0;
    case (state)
      IDLE: begin
        // a waiting sample always wins over a waiting register write
        if (bus.rd_en && (drdy_pend || drdy_fall)) begin
          start_rd  = 1'b1;
          state_nxt = RD_MSW;
        end else if (cfg_busy || cfg_take) begin
          state_nxt = WR_ADR;
        end
      end
      WR_ADR: begin
        cs_n = 1'b0; r_n_w = 1'b0; bus_oe = 1'b1; bus_out = addr_q;
        cnt_last = (cnt == WR_CS_LAST);
        if (cnt_last) state_nxt = WR_ADR_GAP;
      end
      WR_ADR_GAP: begin
        r_n_w = 1'b0;
        cnt_last = (cnt == WR_GAP_LAST);
        if (cnt_last) state_nxt = WR_VAL;
      end
      WR_VAL: begin
        cs_n = 1'b0; r_n_w = 1'b0; bus_oe = 1'b1; bus_out = data_q;
        cnt_last = (cnt == WR_CS_LAST);
        if (cnt_last) state_nxt = WR_VAL_GAP;
      end
      WR_VAL_GAP: begin
        r_n_w = 1'b0;
        cnt_last = (cnt == WR_GAP_LAST);
        if (cnt_last) state_nxt = WR_DONE;
      end
      WR_DONE: begin
        cfg_ack   = 1'b1;
        state_nxt = IDLE;
      end
      RD_MSW: begin
        cs_n = 1'b0;
        cnt_last = (cnt == RD_CS_LAST);
        if (cnt_last) state_nxt = RD_GAP;
      end
      RD_GAP: state_nxt = RD_LSW;
      RD_LSW: begin
        cs_n = 1'b0;
        cnt_last = (cnt == RD_CS_LAST);
        if (cnt_last) state_nxt = RD_DONE;
      end
      RD_DONE: begin
        smp_valid = ~bus.fifo_full;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // control and architecturally visible state
  always_ff @(posedge mclk) begin
    if (i_rest) begin
      state     <= IDLE;
      cnt       <= '0;
      drdy_p0   <= 1'b1;
      drdy_p1   <= 1'b1;
      drdy_p2   <= 1'b1;
      drdy_pend <= 1'b0;
      cfg_busy  <= 1'b0;
      ovr_cnt   <= 8'h00;
      smp_data  <= 32'h0000_0000;
    end else begin
      state   <= state_nxt;
      cnt     <= (state_nxt != state) ? '0 : cnt + 1'b1;
      drdy_p0 <= bus.drdy_n;
      drdy_p1 <= drdy_p0;
      drdy_p2 <= drdy_p1;
      if (!bus.rd_en)
        drdy_pend <= 1'b0;
      else if (start_rd)
        drdy_pend <= drdy_fall & drdy_pend;
      else if (drdy_fall)
        drdy_pend <= 1'b1;
      if (state == WR_DONE)
        cfg_busy <= 1'b0;
      else if (cfg_take)
        cfg_busy <= 1'b1;
      ovr_cnt <= sat_add8(ovr_cnt, {1'b0, ovr_drdy} + {1'b0, ovr_fifo});
      if (state == RD_LSW && cnt_last)
        smp_data <= {msw_q, bus.bus_in};
    end
  end

  // data capture, no reset needed
  always_ff @(posedge mclk) begin
    if (cfg_take) begin
      addr_q <= bus.cfg_addr;
      data_q <= bus.cfg_data;
    end
    if (state == RD_MSW && cnt_last)
      msw_q <= bus.bus_in;
  end

  assign bus.cs_n      = cs_n;
  assign bus.r_n_w     = r_n_w;
  assign bus.bus_oe    = bus_oe;
  assign bus.bus_out   = bus_out;
  assign bus.cfg_ack   = cfg_ack;
  assign bus.cfg_busy  = cfg_busy;
  assign bus.smp_valid = smp_valid;
  assign bus.smp_data  = smp_data;
  assign bus.ovr_cnt   = ovr_cnt;

endmodule
